prn_release_queue: RTL and testbench

//  Retire-side producer for the physical-register free lists. It collects the superseded (Told) PRNs

---
 rtl/prn_release_queue_pkg.sv | 22 ++
 rtl/prn_release_queue_lane_compact.sv | 26 ++
 rtl/prn_release_queue.sv | 192 +++++++++++++++++++
 tb/tb_prn_release_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prn_release_queue_pkg.sv
// Shared types and sizing for the PRN release queue.
// The optional duplicate check is enabled by defining PRN_RELEASE_DUP_CHECK_EN.
package prn_release_queue_pkg;

    localparam int unsigned N                     = 2;
    localparam int unsigned PHYS_REG_SZ_R10K      = 64;
    localparam int unsigned PRN_WIDTH             = $clog2(PHYS_REG_SZ_R10K);
    localparam int unsigned FREE_LIST_CTR_WIDTH   = $clog2(PHYS_REG_SZ_R10K) + 1;
    localparam int unsigned PRN_RELEASE_DEPTH     = 8;
    localparam int unsigned PRN_RELEASE_PTR_WIDTH = $clog2(PRN_RELEASE_DEPTH);
    localparam int unsigned LANE_CNT_WIDTH        = $clog2(N + 1);

    typedef logic [PRN_WIDTH-1:0] prn_t;

    typedef struct packed {
        logic valid;
        prn_t prn;
    } free_list_packet_t;

    localparam int unsigned PKT_WIDTH = $bits(free_list_packet_t);

endpackage

// File: rtl/prn_release_queue_lane_compact.sv
// prn_lane_compact: turns a sparse lane-valid vector into dense per-lane destination
// offsets (count of valid lanes below each lane) plus the total number of valid lanes.
module prn_lane_compact #(
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]       valid_i,
    output logic [LANES*CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]       total_o
);

    logic [CNT_W-1:0] run;

    always_comb begin
        run      = '0;
        offset_o = '0;
        for (int i = 0; i < LANES; i++) begin
            offset_o[i*CNT_W +: CNT_W] = run;
            if (valid_i[i]) begin
                run = run + CNT_W'(1);
            end
        end
        total_o = run;
    end

endmodule

// File: rtl/prn_release_queue.sv
// Circular queue of retired Told PRNs, drained densely into the free list under credit.
// Define PRN_RELEASE_DUP_CHECK_EN to build the in-queue bitmap and duplicate rejection.
module prn_release_queue
    import prn_release_queue_pkg::*;
#(
    parameter int unsigned SIZE  = PHYS_REG_SZ_R10K,
    parameter int unsigned DEPTH = PRN_RELEASE_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N*PKT_WIDTH-1:0]         release_packet,
    input  logic [FREE_LIST_CTR_WIDTH-1:0] push_credit,
    output logic [N*PKT_WIDTH-1:0]         push_packet,
    output logic                           stall,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow,
    output logic                           dup_error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 * N || (DEPTH & (DEPTH - 1)) != 0 || SIZE > (1 << PRN_WIDTH)) begin : g_bad_cfg
        $error("prn_release_queue: DEPTH must be a power of two >= 2*N and SIZE must fit a PRN");
    end

    free_list_packet_t [N-1:0] rel;
    free_list_packet_t [N-1:0] push_vec;

    assign rel         = release_packet;
    assign push_packet = push_vec;

    prn_t             mem_q [DEPTH];
    prn_t             mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [N-1:0]                enq_valid;
    logic [N-1:0]                enq_accept;
    logic [N*LANE_CNT_WIDTH-1:0] enq_offset;
    logic [LANE_CNT_WIDTH-1:0]   enq_total;
    logic [LANE_CNT_WIDTH-1:0]   enq_m;
    logic [LANE_CNT_WIDTH-1:0]   deq_k;

    int unsigned               k_tmp;
    int unsigned               cap;
    int unsigned               m_tmp;
    logic [LANE_CNT_WIDTH-1:0] off;

    // k = min(N, count, credit); credit above N is clamped here.
    always_comb begin
        k_tmp = N;
        if (32'(count_q) < k_tmp) begin
            k_tmp = 32'(count_q);
        end
        if (32'(push_credit) < k_tmp) begin
            k_tmp = 32'(push_credit);
        end
        deq_k = LANE_CNT_WIDTH'(k_tmp);
    end

    always_comb begin
        push_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(deq_k)) begin
                push_vec[i].valid = 1'b1;
                push_vec[i].prn   = mem_q[head_q + PTR_W'(i)];
            end
        end
    end

`ifdef PRN_RELEASE_DUP_CHECK_EN
    logic [SIZE-1:0] in_queue_q, in_queue_d;
    logic            dup_error_q, dup_error_d;
    logic            dup_hit;
    logic            seen;

    // Drop a lane whose PRN is already queued or repeats a lower lane this cycle.
    always_comb begin
        enq_valid = '0;
        dup_hit   = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rel[i].valid) begin
                seen = in_queue_q[rel[i].prn];
                for (int j = 0; j < i; j++) begin
                    if (rel[j].valid && rel[j].prn == rel[i].prn) begin
                        seen = 1'b1;
                    end
                end
                enq_valid[i] = !seen;
                dup_hit      = dup_hit | seen;
            end
        end
    end

    always_comb begin
        in_queue_d = in_queue_q;
        for (int i = 0; i < N; i++) begin
            if (push_vec[i].valid) begin
                in_queue_d[push_vec[i].prn] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (enq_accept[i]) begin
                in_queue_d[rel[i].prn] = 1'b1;
            end
        end
        dup_error_d = dup_error_q | dup_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_queue_q  <= '0;
            dup_error_q <= 1'b0;
        end else begin
            in_queue_q  <= in_queue_d;
            dup_error_q <= dup_error_d;
        end
    end

    assign dup_error = dup_error_q;
`else
    always_comb begin
        enq_valid = '0;
        for (int i = 0; i < N; i++) begin
            enq_valid[i] = rel[i].valid;
        end
    end

    assign dup_error = 1'b0;
`endif

    prn_lane_compact #(
        .LANES (N),
        .CNT_W (LANE_CNT_WIDTH)
    ) u_lane_compact (
        .valid_i  (enq_valid),
        .offset_o (enq_offset),
        .total_o  (enq_total)
    );

    // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
    always_comb begin
        cap   = DEPTH - 32'(count_q) + 32'(deq_k);
        m_tmp = 32'(enq_total);
        if (cap < m_tmp) begin
            m_tmp = cap;
        end
        enq_m      = LANE_CNT_WIDTH'(m_tmp);
        enq_accept = '0;
        off        = '0;
        mem_d      = mem_q;
        for (int i = 0; i < N; i++) begin
            off = enq_offset[i*LANE_CNT_WIDTH +: LANE_CNT_WIDTH];
            if (enq_valid[i] && (32'(off) < cap)) begin
                enq_accept[i]                 = 1'b1;
                mem_d[tail_q + PTR_W'(off)] = rel[i].prn;
            end
        end
        head_d     = head_q + PTR_W'(deq_k);
        tail_d     = tail_q + PTR_W'(enq_m);
        count_d    = count_q - CNT_W'(deq_k) + CNT_W'(enq_m);
        overflow_d = overflow_q | (|(enq_valid & ~enq_accept));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: only entries between head and tail are ever read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign stall    = (CNT_W'(DEPTH) - count_q) < CNT_W'(N);

endmodule

// File: tb/tb_prn_release_queue.sv
// Scoreboard bench for prn_release_queue (N=2, DEPTH=8); a negedge monitor checks pushes.
module tb_prn_release_queue;
    import prn_release_queue_pkg::*;

    logic                                 clock = 1'b0;
    logic                                 reset;
    logic [N*PKT_WIDTH-1:0]               release_packet;
    logic [FREE_LIST_CTR_WIDTH-1:0]       push_credit;
    logic [N*PKT_WIDTH-1:0]               push_packet;
    logic                                 stall;
    logic [$clog2(PRN_RELEASE_DEPTH):0]   count;
    logic                                 overflow;
    logic                                 dup_error;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit mon_en = 1'b0;

    logic [PKT_WIDTH-1:0] mon_lane;
    logic                 mon_prev;

    prn_release_queue u_dut (
        .clock          (clock),
        .reset          (reset),
        .release_packet (release_packet),
        .push_credit    (push_credit),
        .push_packet    (push_packet),
        .stall          (stall),
        .count          (count),
        .overflow       (overflow),
        .dup_error      (dup_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*PKT_WIDTH-1:0] pack(input bit v0, input int p0,
                                                    input bit v1, input int p1);
        logic [N*PKT_WIDTH-1:0] r;
        r = '0;
        r[0 +: PKT_WIDTH]         = {v0, PRN_WIDTH'(p0)};
        r[PKT_WIDTH +: PKT_WIDTH] = {v1, PRN_WIDTH'(p1)};
        return r;
    endfunction

    task automatic step(input bit v0, input int p0, input bit v1, input int p1);
        release_packet = pack(v0, p0, v1, p1);
        @(posedge clock);
        #1;
        release_packet = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: every valid lane must be the next expected PRN, lanes dense, idle lanes zero.
    always @(negedge clock) begin
        if (mon_en) begin
            mon_prev = 1'b1;
            for (int i = 0; i < N; i++) begin
                mon_lane = push_packet[i*PKT_WIDTH +: PKT_WIDTH];
                if (mon_lane[PKT_WIDTH-1]) begin
                    check("push dense", int'(mon_prev), 1);
                    if (exp_q.size() == 0) begin
                        check("push unexpected", int'(mon_lane[PRN_WIDTH-1:0]), -1);
                    end else begin
                        check("push prn", int'(mon_lane[PRN_WIDTH-1:0]), exp_q.pop_front());
                    end
                end else begin
                    check("idle lane prn", int'(mon_lane[PRN_WIDTH-1:0]), 0);
                end
                mon_prev = mon_lane[PKT_WIDTH-1];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        release_packet = '0;
        push_credit    = '0;
        idle(2);
        reset = 1'b0;
        check("reset count", int'(count), 0);
        check("reset stall", int'(stall), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset dup_error", int'(dup_error), 0);
        check("reset push_packet", int'(push_packet), 0);
        mon_en = 1'b1;

        // 1: dense pair, credit above N is clamped
        push_credit = 7;
        step(1, 40, 1, 41);
        exp_q.push_back(40);
        exp_q.push_back(41);
        check("t1 count", int'(count), 2);
        idle(1);
        check("t1 drained", int'(count), 0);

        // 2: sparse release packs into lane 0
        step(0, 0, 1, 50);
        exp_q.push_back(50);
        check("t2 count", int'(count), 1);
        idle(1);
        check("t2 drained", int'(count), 0);

        // 3: no credit fills, then credit 1 drains one per cycle
        push_credit = 0;
        step(1, 10, 1, 11);
        step(1, 12, 1, 13);
        step(1, 14, 1, 15);
        for (int p = 10; p <= 15; p++) exp_q.push_back(p);
        check("t3 count", int'(count), 6);
        check("t3 stall at 6", int'(stall), 0);
        push_credit = 1;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("t3 drain count", int'(count), 5 - i);
        end

        // 4: fill to 7 across the pointer wrap, then drain across it
        push_credit = 0;
        step(1, 20, 1, 21);
        step(1, 22, 1, 23);
        step(1, 24, 1, 25);
        step(0, 0, 1, 26);
        for (int p = 20; p <= 26; p++) exp_q.push_back(p);
        check("t4 count", int'(count), 7);
        check("t4 stall at 7", int'(stall), 1);
        push_credit = 2;
        idle(1);
        check("t4 drain a", int'(count), 5);
        idle(1);
        check("t4 drain b", int'(count), 3);
        idle(1);
        check("t4 drain c", int'(count), 1);
        idle(1);
        check("t4 drain d", int'(count), 0);

        // full queue: simultaneous dequeue frees room for the same-cycle enqueue
        push_credit = 0;
        step(1, 30, 1, 31);
        step(1, 32, 1, 33);
        step(1, 34, 1, 35);
        step(1, 36, 1, 37);
        for (int p = 30; p <= 37; p++) exp_q.push_back(p);
        check("full count", int'(count), 8);
        check("full stall", int'(stall), 1);
        push_credit = 2;
        step(1, 38, 1, 39);
        exp_q.push_back(38);
        exp_q.push_back(39);
        check("full swap count", int'(count), 8);
        check("full swap overflow", int'(overflow), 0);

        // 5: one slot freed -> lane 1 trimmed; then no credit -> both lanes dropped
        push_credit = 1;
        step(1, 42, 1, 43);
        exp_q.push_back(42);
        check("t5 trim count", int'(count), 8);
        check("t5 trim overflow", int'(overflow), 1);
        push_credit = 0;
        step(1, 44, 1, 45);
        check("t5 drop count", int'(count), 8);
        check("t5 drop overflow", int'(overflow), 1);
        exp_q.delete();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("t5 reset count", int'(count), 0);
        check("t5 reset overflow", int'(overflow), 0);
        check("t5 reset stall", int'(stall), 0);
        check("t5 reset push_packet", int'(push_packet), 0);

        // 6: duplicate PRN in one cycle, then again while queued
        step(1, 60, 1, 60);
`ifdef PRN_RELEASE_DUP_CHECK_EN
        exp_q.push_back(60);
        check("t6 count", int'(count), 1);
        check("t6 dup_error", int'(dup_error), 1);
        step(1, 60, 0, 0);
        check("t6 requeue count", int'(count), 1);
`else
        exp_q.push_back(60);
        exp_q.push_back(60);
        check("t6 count", int'(count), 2);
        check("t6 dup_error", int'(dup_error), 0);
        step(1, 60, 0, 0);
        exp_q.push_back(60);
        check("t6 requeue count", int'(count), 3);
`endif
        push_credit = 2;
        idle(2);
        check("t6 drained", int'(count), 0);

        idle(2);
        check("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
